// File: rtl/alu_sys_pkg.sv
// rtl/alu_sys_pkg.sv - shared constants and state encoding for the ALU command path
package alu_sys_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ALU_FUN_WIDTH = 4;

    localparam logic [7:0] CMD_OP  = 8'hCC;
    localparam logic [7:0] CMD_NOP = 8'hDD;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        GET_FUN  = 3'd3,
        EXEC     = 3'd4,
        WAIT_ALU = 3'd5,
        SEND_LO  = 3'd6,
        SEND_HI  = 3'd7
    } alu_state_e;

endpackage

// File: rtl/alu_tx_serializer.sv
// rtl/alu_tx_serializer.sv - shifts a 2-byte ALU result out as a valid/busy byte stream
module alu_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [2*DATA_WIDTH-1:0] result,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tdata,
    output logic                    tvalid
);

    logic [DATA_WIDTH-1:0] hi_byte;
    logic                  hi_pending;

    // A byte transfers on any edge where tvalid is high and the transmitter is not busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata      <= '0;
            tvalid     <= 1'b0;
            hi_byte    <= '0;
            hi_pending <= 1'b0;
        end else if (load) begin
            tdata      <= result[DATA_WIDTH-1:0];
            hi_byte    <= result[2*DATA_WIDTH-1:DATA_WIDTH];
            tvalid     <= 1'b1;
            hi_pending <= 1'b1;
        end else if (tvalid && !tx_busy) begin
            if (hi_pending) begin
                tdata      <= hi_byte;
                hi_pending <= 1'b0;
            end else begin
                tdata  <= '0;
                tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - parses RX command frames, drives the ALU and returns its result over TX
module alu_cmd_ctrl
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ALU_FUN_WIDTH = DEF_ALU_FUN_WIDTH,
    parameter int TIMEOUT       = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VALID,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VALID,
    input  logic                    TX_BUSY,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                    ALU_EN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VALID,
    output logic                    ERR,
    output logic                    OVERRUN
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    alu_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             fun_bad;
    logic             tx_fire;
    logic             result_load;
    logic             busy_state;

    assign fun_bad     = (RX_P_DATA >> ALU_FUN_WIDTH) != '0;
    assign tx_fire     = TX_D_VALID && !TX_BUSY;
    assign result_load = (state == WAIT_ALU) && ALU_OUT_VALID;
    assign busy_state  = (state == EXEC) || (state == WAIT_ALU) ||
                         (state == SEND_LO) || (state == SEND_HI);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ALU_A       <= '0;
            ALU_B       <= '0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            ERR         <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            ALU_EN  <= 1'b0;
            ERR     <= 1'b0;
            OVERRUN <= RX_D_VALID && busy_state;
            case (state)
                IDLE: begin
                    if (RX_D_VALID) begin
                        if (RX_P_DATA == DATA_WIDTH'(CMD_OP))
                            state <= GET_A;
                        else if (RX_P_DATA == DATA_WIDTH'(CMD_NOP))
                            state <= GET_FUN;
                    end
                end
                GET_A: begin
                    if (RX_D_VALID) begin
                        ALU_A <= RX_P_DATA;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (RX_D_VALID) begin
                        ALU_B <= RX_P_DATA;
                        state <= GET_FUN;
                    end
                end
                GET_FUN: begin
                    if (RX_D_VALID) begin
                        if (fun_bad) begin
                            ERR   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ALU_FUN     <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
                            ALU_EN      <= 1'b1;
                            CLK_GATE_EN <= 1'b1;
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    wait_cnt <= '0;
                    state    <= WAIT_ALU;
                end
                WAIT_ALU: begin
                    // The ALU clock stays on through the cycle its result is seen.
                    if (ALU_OUT_VALID) begin
                        CLK_GATE_EN <= 1'b0;
                        state       <= SEND_LO;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        ERR         <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SEND_LO: begin
                    if (tx_fire)
                        state <= SEND_HI;
                end
                SEND_HI: begin
                    if (tx_fire)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    alu_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_ser (
        .clk     (CLK),
        .rst_n   (RST),
        .load    (result_load),
        .result  (ALU_OUT),
        .tx_busy (TX_BUSY),
        .tdata   (TX_P_DATA),
        .tvalid  (TX_D_VALID)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed self-checking bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VALID = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VALID = 1'b0;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, CLK_GATE_EN, TX_D_VALID, ERR, OVERRUN;

    int checks = 0;
    int passes = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] tx_q[$];

    alu_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VALID    (RX_D_VALID),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VALID (ALU_OUT_VALID),
        .TX_BUSY       (TX_BUSY),
        .ALU_A         (ALU_A),
        .ALU_B         (ALU_B),
        .ALU_FUN       (ALU_FUN),
        .ALU_EN        (ALU_EN),
        .CLK_GATE_EN   (CLK_GATE_EN),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VALID    (TX_D_VALID),
        .ERR           (ERR),
        .OVERRUN       (OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Pulse counters and the transmitted-byte log, sampled mid-cycle.
    always @(negedge CLK) begin
        if (ALU_EN) en_cnt++;
        if (ERR) err_cnt++;
        if (OVERRUN) ovr_cnt++;
        if (TX_D_VALID && !TX_BUSY) tx_q.push_back(TX_P_DATA);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, want finish before 100000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA  = b;
        RX_D_VALID = 1'b1;
        tick();
        RX_D_VALID = 1'b0;
    endtask

    task automatic alu_reply(input logic [15:0] res);
        ALU_OUT       = res;
        ALU_OUT_VALID = 1'b1;
        tick();
        ALU_OUT_VALID = 1'b0;
    endtask

    task automatic wait_tx_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!TX_D_VALID) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VALID, ERR, OVERRUN} !== '0)
            $display("FAIL reset_outputs: got A=%h B=%h FUN=%h EN=%b GATE=%b TX=%h TV=%b ERR=%b OVR=%b, want all 0",
                     ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VALID, ERR, OVERRUN);
        else passes++;
        tick();
        tick();
        RST = 1'b1;
        tick();
    endtask

    task automatic test_op_frame();
        int e0, r0;
        bit to;
        tx_q.delete();
        e0 = en_cnt;
        r0 = err_cnt;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        checks++;
        if (ALU_EN !== 1'b1 || CLK_GATE_EN !== 1'b1)
            $display("FAIL op_en_latency: EN=%b GATE=%b, want 1 1", ALU_EN, CLK_GATE_EN);
        else passes++;
        checks++;
        if (ALU_A !== 8'h12 || ALU_B !== 8'h34 || ALU_FUN !== 4'h0)
            $display("FAIL op_operands: A=%h B=%h FUN=%h, want 12 34 0", ALU_A, ALU_B, ALU_FUN);
        else passes++;
        tick();
        checks++;
        if (ALU_EN !== 1'b0 || CLK_GATE_EN !== 1'b1)
            $display("FAIL op_en_one_cycle: EN=%b GATE=%b, want 0 1", ALU_EN, CLK_GATE_EN);
        else passes++;
        tick();
        alu_reply(16'h0046);
        checks++;
        if (TX_D_VALID !== 1'b1 || TX_P_DATA !== 8'h46 || CLK_GATE_EN !== 1'b0)
            $display("FAIL op_tx_latency: TV=%b TX=%h GATE=%b, want 1 46 0", TX_D_VALID, TX_P_DATA, CLK_GATE_EN);
        else passes++;
        wait_tx_idle(to);
        checks++;
        if (to || tx_q.size() != 2 || tx_q[0] !== 8'h46 || tx_q[1] !== 8'h00)
            $display("FAIL op_tx_bytes: timeout=%0d n=%0d b0=%h b1=%h, want 0 2 46 00", to, tx_q.size(), tx_q[0], tx_q[1]);
        else passes++;
        checks++;
        if (en_cnt - e0 != 1 || err_cnt != r0)
            $display("FAIL op_pulses: en=%0d err=%0d, want 1 0", en_cnt - e0, err_cnt - r0);
        else passes++;
    endtask

    task automatic test_nop_frame();
        bit to;
        tx_q.delete();
        send_byte(8'hDD); send_byte(8'h05);
        checks++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h5 || ALU_A !== 8'h12 || ALU_B !== 8'h34)
            $display("FAIL nop_latch: EN=%b FUN=%h A=%h B=%h, want 1 5 12 34", ALU_EN, ALU_FUN, ALU_A, ALU_B);
        else passes++;
        tick();
        alu_reply(16'hABCD);
        wait_tx_idle(to);
        checks++;
        if (to || tx_q.size() != 2 || tx_q[0] !== 8'hCD || tx_q[1] !== 8'hAB)
            $display("FAIL nop_tx_bytes: timeout=%0d n=%0d b0=%h b1=%h, want 0 2 CD AB", to, tx_q.size(), tx_q[0], tx_q[1]);
        else passes++;
    endtask

    task automatic test_bad_fun();
        int e0;
        e0 = en_cnt;
        send_byte(8'h55);
        tick();
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h20);
        checks++;
        if (ERR !== 1'b1 || ALU_EN !== 1'b0 || CLK_GATE_EN !== 1'b0)
            $display("FAIL badfun_err: ERR=%b EN=%b GATE=%b, want 1 0 0", ERR, ALU_EN, CLK_GATE_EN);
        else passes++;
        checks++;
        if (ALU_FUN !== 4'h5 || ALU_A !== 8'h01 || ALU_B !== 8'h02)
            $display("FAIL badfun_hold: FUN=%h A=%h B=%h, want 5 01 02", ALU_FUN, ALU_A, ALU_B);
        else passes++;
        tick();
        checks++;
        if (ERR !== 1'b0 || en_cnt != e0)
            $display("FAIL badfun_pulse: ERR=%b en_pulses=%0d, want 0 0", ERR, en_cnt - e0);
        else passes++;
    endtask

    task automatic test_timeout();
        bit early;
        bit to;
        send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h01);
        tick();
        early = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (ERR !== 1'b0 || CLK_GATE_EN !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early) $display("FAIL timeout_early: ERR or GATE changed before 16 cycles, want ERR=0 GATE=1");
        else passes++;
        tick();
        checks++;
        if (ERR !== 1'b1 || CLK_GATE_EN !== 1'b0)
            $display("FAIL timeout_err: ERR=%b GATE=%b, want 1 0", ERR, CLK_GATE_EN);
        else passes++;
        tick();
        checks++;
        if (ERR !== 1'b0) $display("FAIL timeout_pulse: ERR=%b, want 0", ERR);
        else passes++;
        tx_q.delete();
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h08); send_byte(8'h02);
        checks++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h2 || ALU_A !== 8'h07)
            $display("FAIL timeout_next_en: EN=%b FUN=%h A=%h, want 1 2 07", ALU_EN, ALU_FUN, ALU_A);
        else passes++;
        tick();
        alu_reply(16'h1234);
        wait_tx_idle(to);
        checks++;
        if (to || tx_q.size() != 2 || tx_q[0] !== 8'h34 || tx_q[1] !== 8'h12)
            $display("FAIL timeout_next_tx: timeout=%0d n=%0d b0=%h b1=%h, want 0 2 34 12", to, tx_q.size(), tx_q[0], tx_q[1]);
        else passes++;
    endtask

    task automatic test_busy_overrun();
        int o0, e0;
        bit stable;
        bit to;
        tx_q.delete();
        TX_BUSY = 1'b1;
        send_byte(8'hCC); send_byte(8'h09); send_byte(8'h0A); send_byte(8'h03);
        tick();
        alu_reply(16'hBEEF);
        o0 = ovr_cnt;
        e0 = en_cnt;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(8'h77);
            else tick();
            if (TX_D_VALID !== 1'b1 || TX_P_DATA !== 8'hEF) stable = 1'b0;
        end
        checks++;
        if (!stable) $display("FAIL busy_hold: TV=%b TX=%h, want 1 EF held", TX_D_VALID, TX_P_DATA);
        else passes++;
        checks++;
        if (ovr_cnt - o0 != 1 || en_cnt != e0 || ALU_A !== 8'h09 || tx_q.size() != 0)
            $display("FAIL busy_overrun: ovr=%0d en=%0d A=%h sent=%0d, want 1 0 09 0",
                     ovr_cnt - o0, en_cnt - e0, ALU_A, tx_q.size());
        else passes++;
        TX_BUSY = 1'b0;
        wait_tx_idle(to);
        checks++;
        if (to || tx_q.size() != 2 || tx_q[0] !== 8'hEF || tx_q[1] !== 8'hBE)
            $display("FAIL busy_tx_bytes: timeout=%0d n=%0d b0=%h b1=%h, want 0 2 EF BE", to, tx_q.size(), tx_q[0], tx_q[1]);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        send_byte(8'hCC); send_byte(8'h11);
        checks++;
        if (ALU_A !== 8'h11) $display("FAIL rst_pre_a: A=%h, want 11", ALU_A);
        else passes++;
        RST = 1'b0;
        #1;
        checks++;
        if ({ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VALID, ERR, OVERRUN} !== '0)
            $display("FAIL rst_async: A=%h B=%h FUN=%h EN=%b GATE=%b TX=%h TV=%b, want all 0",
                     ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VALID);
        else passes++;
        tick();
        RST = 1'b1;
        tx_q.delete();
        send_byte(8'hCC); send_byte(8'h21); send_byte(8'h22); send_byte(8'h04);
        checks++;
        if (ALU_EN !== 1'b1 || ALU_A !== 8'h21 || ALU_B !== 8'h22 || ALU_FUN !== 4'h4)
            $display("FAIL rst_next_frame: EN=%b A=%h B=%h FUN=%h, want 1 21 22 4", ALU_EN, ALU_A, ALU_B, ALU_FUN);
        else passes++;
        tick();
        alu_reply(16'h5566);
        wait_tx_idle(to);
        checks++;
        if (to || tx_q.size() != 2 || tx_q[0] !== 8'h66 || tx_q[1] !== 8'h55)
            $display("FAIL rst_next_tx: timeout=%0d n=%0d b0=%h b1=%h, want 0 2 66 55", to, tx_q.size(), tx_q[0], tx_q[1]);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_op_frame();
        test_nop_frame();
        test_bad_fun();
        test_timeout();
        test_busy_overrun();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
